// File: rtl/dram_1w2r_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dram_1w2r_pkg : address-width helper for the 1W/2R distributed RAM
// Rev 1.0
// ---------------------------------------------------------------------------
package dram_1w2r_pkg;

  // Ceiling log2 with a floor of 1 so a 2-entry (or smaller) RAM still has an address bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_1w2r.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dram_1w2r : SZ x DW RAM, one synchronous write port, two combinational reads
// Rev 1.0
// ---------------------------------------------------------------------------
module dram_1w2r
  import dram_1w2r_pkg::*;
#(
  parameter int SZ = 2,
  parameter int DW = 32,
  localparam int AW = clog2(SZ)
) (
  input  logic          clk1_i,
  input  logic          rst_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] i1,
  output logic [DW-1:0] o0,
  output logic [DW-1:0] o1
);

  logic [DW-1:0] r_mem [SZ] = '{default: '0};
  logic          w_in0;
  logic          w_in1;

  // Addresses at or above SZ only exist when SZ is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(SZ);
  endfunction

  assign w_in0 = in_range(addr0_i);
  assign w_in1 = in_range(addr1_i);

  always_ff @(posedge clk1_i) begin
    if (!rst_i) begin
      for (int i = 0; i < SZ; i++) r_mem[i] <= '0;
    end else if (we1_i && w_in1) begin
      r_mem[addr1_i] <= i1;
    end
  end

  assign o0 = w_in0 ? r_mem[addr0_i] : '0;
  assign o1 = w_in1 ? r_mem[addr1_i] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dram_1w2r.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dram_1w2r : scoreboard bench over SZ=4/DW=32, SZ=3/DW=8 and SZ=2/DW=2
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dram_1w2r;
  import dram_1w2r_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SZ=4, DW=32
  logic        a_rst = 1'b1, a_we = 1'b0;
  logic [1:0]  a_a0 = '0, a_a1 = '0;
  logic [31:0] a_i1 = '0, a_o0, a_o1;
  // Instance B: SZ=3, DW=8
  logic        b_rst = 1'b1, b_we = 1'b0;
  logic [1:0]  b_a0 = '0, b_a1 = '0;
  logic [7:0]  b_i1 = '0, b_o0, b_o1;
  // Instance C: SZ=2, DW=2 (never reset, never written)
  logic        c_rst = 1'b1, c_we = 1'b0;
  logic [0:0]  c_a0 = '0, c_a1 = '0;
  logic [1:0]  c_i1 = '0, c_o0, c_o1;

  dram_1w2r #(.SZ(4), .DW(32)) u_a (
    .clk1_i(clk), .rst_i(a_rst), .we1_i(a_we), .addr0_i(a_a0), .addr1_i(a_a1),
    .i1(a_i1), .o0(a_o0), .o1(a_o1));
  dram_1w2r #(.SZ(3), .DW(8)) u_b (
    .clk1_i(clk), .rst_i(b_rst), .we1_i(b_we), .addr0_i(b_a0), .addr1_i(b_a1),
    .i1(b_i1), .o0(b_o0), .o1(b_o1));
  dram_1w2r #(.SZ(2), .DW(2)) u_c (
    .clk1_i(clk), .rst_i(c_rst), .we1_i(c_we), .addr0_i(c_a0), .addr1_i(c_a1),
    .i1(c_i1), .o0(c_o0), .o1(c_o1));

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs0(input int d);
    case (d)
      0:       return a_o0;
      1:       return {24'b0, b_o0};
      default: return {30'b0, c_o0};
    endcase
  endfunction

  function automatic logic [31:0] obs1(input int d);
    case (d)
      0:       return a_o1;
      1:       return {24'b0, b_o1};
      default: return {30'b0, c_o1};
    endcase
  endfunction

  // Drive both read addresses, queue the expected data, then pop and compare once settled.
  task automatic rd(input int d, input string tag, input logic [1:0] a0, input logic [1:0] a1,
                    input logic [31:0] e0, input logic [31:0] e1);
    exp_t e;
    case (d)
      0:       begin a_a0 = a0; a_a1 = a1; end
      1:       begin b_a0 = a0; b_a1 = a1; end
      default: begin c_a0 = a0[0:0]; c_a1 = a1[0:0]; end
    endcase
    q_exp.push_back('{{tag, ".o0"}, e0});
    q_exp.push_back('{{tag, ".o1"}, e1});
    #1;
    e = q_exp.pop_front();
    chk(e.tag, obs0(d), e.v);
    e = q_exp.pop_front();
    chk(e.tag, obs1(d), e.v);
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    a_we = 1'b1; a_a1 = a; a_i1 = v;
    @(posedge clk); #1;
    a_we = 1'b0;
  endtask

  task automatic wr_b(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    b_we = 1'b1; b_a1 = a; b_i1 = v;
    @(posedge clk); #1;
    b_we = 1'b0;
  endtask

  initial begin
    // Power-up contents, no writes, no reset
    #2;
    rd(2, "pwr_01", 2'd0, 2'd1, 32'h0, 32'h0);
    rd(2, "pwr_10", 2'd1, 2'd0, 32'h0, 32'h0);
    rd(2, "pwr_11", 2'd1, 2'd1, 32'h0, 32'h0);

    // Write with same-address read: old value before the edge, new right after
    @(negedge clk);
    a_we = 1'b1; a_i1 = 32'hDEADBEEF;
    rd(0, "wr_pre", 2'd2, 2'd2, 32'h0, 32'h0);
    @(posedge clk); #1;
    a_we = 1'b0;
    rd(0, "wr_post", 2'd2, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF);

    // Independent ports
    wr_a(2'd0, 32'h11);
    wr_a(2'd1, 32'h22);
    wr_a(2'd3, 32'h44);
    rd(0, "ind_13", 2'd1, 2'd3, 32'h22, 32'h44);
    rd(0, "ind_03", 2'd0, 2'd3, 32'h11, 32'h44);
    rd(0, "ind_22", 2'd2, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF);

    // Reset wins over a simultaneous write and clears every entry
    @(negedge clk);
    a_rst = 1'b0; a_we = 1'b1; a_a1 = 2'd1; a_i1 = 32'hFF;
    @(posedge clk); #1;
    a_rst = 1'b1; a_we = 1'b0;
    rd(0, "rst_01", 2'd0, 2'd1, 32'h0, 32'h0);
    rd(0, "rst_23", 2'd2, 2'd3, 32'h0, 32'h0);
    wr_a(2'd1, 32'h5);
    rd(0, "rst_wr", 2'd1, 2'd0, 32'h5, 32'h0);

    // Non-power-of-two size: out-of-range write is dropped, read returns 0
    wr_b(2'd0, 8'h10);
    wr_b(2'd1, 8'h20);
    wr_b(2'd2, 8'h30);
    wr_b(2'd3, 8'hAA);
    rd(1, "oor_01", 2'd0, 2'd1, 32'h10, 32'h20);
    rd(1, "oor_23", 2'd2, 2'd3, 32'h30, 32'h0);
    rd(1, "oor_30", 2'd3, 2'd0, 32'h0, 32'h10);

    // Back-to-back writes to one address on consecutive edges
    @(negedge clk);
    b_we = 1'b1; b_a1 = 2'd1; b_i1 = 8'h01;
    @(posedge clk); #1;
    b_i1 = 8'h02;
    rd(1, "b2b_1", 2'd0, 2'd1, 32'h10, 32'h01);
    @(posedge clk); #1;
    b_we = 1'b0;
    rd(1, "b2b_2", 2'd2, 2'd1, 32'h30, 32'h02);
    rd(1, "b2b_oth", 2'd0, 2'd2, 32'h10, 32'h30);

    // Reset on the odd-sized instance
    @(negedge clk);
    b_rst = 1'b0;
    @(posedge clk); #1;
    b_rst = 1'b1;
    rd(1, "brst_01", 2'd0, 2'd1, 32'h0, 32'h0);
    rd(1, "brst_2", 2'd2, 2'd2, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
